// File: rtl/gat_feat_readout.sv
// Drains the GAT new-feature BRAM into a valid/ready stream: sweeps port B with
// byte addresses and absorbs the fixed read latency in a credit-limited FIFO.
module gat_feat_readout #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LAT             = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [NEW_FEATURE_ADDR_W:0]     num_words,
    input  logic                            gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            busy,
    output logic                            done
);

    localparam int AW   = NEW_FEATURE_ADDR_W;
    localparam int NW   = NEW_FEATURE_ADDR_W + 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int IW   = $clog2(RD_LAT + 1);
    localparam int OW   = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                     r_state;
    logic [NW-1:0]              r_n_req;
    logic [AW-1:0]              r_rd_idx;
    logic [NW-1:0]              r_out_idx;
    logic                       r_last_acc;
    logic                       r_busy;
    logic                       r_done;
    logic [RD_LAT-1:0]          r_tag;
    logic [NEW_FEATURE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [CNTW-1:0]            r_count;

    logic [NW-1:0]              w_nsat;
    logic [NW-1:0]              w_last_idx;
    logic [IW-1:0]              w_inflight;
    logic [OW-1:0]              w_occ;
    logic                       w_issue;
    logic                       w_push;
    logic                       w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_nsat     = (num_words > NW'(NEW_FEATURE_DEPTH)) ? NW'(NEW_FEATURE_DEPTH) : num_words;
    assign w_last_idx = r_n_req - NW'(1);

    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + IW'(r_tag[i]);
        end
    end

    // Credit covers both buffered words and reads still in the BRAM pipe.
    assign w_occ   = OW'(r_count) + OW'(w_inflight);
    assign w_issue = (r_state == S_READ) && (w_occ < OW'(FIFO_DEPTH));
    assign w_push  = r_tag[RD_LAT-1];
    assign w_pop   = (r_count != '0) && m_tready;

    assign feat_bram_addrb = {r_rd_idx, 2'b00};
    assign m_tvalid        = (r_count != '0);
    assign m_tdata         = r_mem[r_rptr];
    assign m_tlast         = m_tvalid && (r_out_idx == w_last_idx);
    assign busy            = r_busy;
    assign done            = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_n_req    <= '0;
            r_rd_idx   <= '0;
            r_out_idx  <= '0;
            r_last_acc <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_out_idx <= r_out_idx + NW'(1);
                if (m_tlast) begin
                    r_last_acc <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n_req    <= w_nsat;
                        r_rd_idx   <= '0;
                        r_out_idx  <= '0;
                        r_last_acc <= 1'b0;
                        if (w_nsat == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_WAIT_RDY;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (gat_ready) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        // Hold the final address rather than stepping past the range.
                        if ({1'b0, r_rd_idx} == w_last_idx) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_rd_idx <= r_rd_idx + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if ((w_inflight == '0) && (r_count == '0) && r_last_acc) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= feat_bram_dout;
                r_wptr        <= f_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_gat_feat_readout.sv
// Randomized bench for gat_feat_readout: a latency-accurate BRAM model feeds the
// DUT and every emitted beat is scored against the expected word list of the run.
module tb_gat_feat_readout;

    localparam int W     = 32;
    localparam int DEPTH = 2708 * 16;
    localparam int AW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW:0]     num_words;
    logic            gat_ready;
    logic [AW+1:0]   feat_bram_addrb;
    logic [W-1:0]    feat_bram_dout;
    logic [W-1:0]    m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic            busy;
    logic            done;

    logic [W-1:0]    base = 32'hA500_0000;
    logic [W-1:0]    q0, q1;
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              beat_cnt, done_cnt, first_cyc, last_cyc;
    bit              rdy_mode = 1'b0;
    bit              prev_stall = 1'b0;
    logic [W-1:0]    prev_data;
    logic            prev_last;
    logic [W-1:0]    exp_q[$];
    logic [AW+1:0]   addr_q[$];

    gat_feat_readout #(
        .NEW_FEATURE_WIDTH(W),
        .NUM_SUBGRAPHS(2708),
        .NUM_FEATURE_OUT(16),
        .RD_LAT(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_words(num_words),
        .gat_ready(gat_ready),
        .feat_bram_addrb(feat_bram_addrb),
        .feat_bram_dout(feat_bram_dout),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // BRAM: data for the address seen in cycle c appears in cycle c+2.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        q0  <= base + W'(feat_bram_addrb >> 2);
        q1  <= q0;
    end
    assign feat_bram_dout = q1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, prev_data);
                check("hold_last", m_tlast, prev_last);
            end
            if (busy) begin
                check("addr_lsb", feat_bram_addrb[1:0], 0);
                if (addr_q.size() == 0 || addr_q[$] != feat_bram_addrb)
                    addr_q.push_back(feat_bram_addrb);
            end
            if (m_tvalid && m_tready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("tlast", m_tlast, exp_q.size() == 1);
                    check("tdata", m_tdata, exp_q.pop_front());
                end
                beat_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            tick();
            m_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_run(input int n, input logic [W-1:0] b);
        base = b;
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(b + W'(i));
        beat_cnt  = 0;
        done_cnt  = 0;
        first_cyc = -1;
        last_cyc  = -1;
        num_words = (AW+1)'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_beats(input int k, input int budget);
        for (int i = 0; i < budget && beat_cnt < k; i++) tick();
        check("beats_reached", beat_cnt >= k, 1);
    endtask

    task automatic finish_run(input int n, input bit span);
        for (int i = 0; i < n * 10 + 200 && done_cnt == 0; i++) tick();
        check("done_seen", done_cnt != 0, 1);
        repeat (6) tick();
        check("beat_count", beat_cnt, n);
        check("done_count", done_cnt, 1);
        check("exp_left", exp_q.size(), 0);
        check("addr_count", addr_q.size(), n);
        for (int i = 0; i < addr_q.size() && i < n; i++) check("addr_seq", addr_q[i], 4 * i);
        if (span) check("burst_span", last_cyc - first_cyc, n - 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_addrb", feat_bram_addrb, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_words = '0; gat_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic 16-word drain with ready already high and no backpressure.
        gat_ready = 1'b1;
        start_run(16, 32'hA500_0000);
        finish_run(16, 1'b1);

        // Accelerator not ready for 50 cycles.
        gat_ready = 1'b0;
        start_run(int'($urandom_range(10, 30)), $urandom);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("wait_addrb", feat_bram_addrb, 0);
            check("wait_tvalid", m_tvalid, 0);
            check("wait_busy", busy, 1);
        end
        tick();
        gat_ready = 1'b1;
        finish_run(exp_q.size(), 1'b1);

        // 40 words under random backpressure.
        rdy_mode = 1'b1;
        start_run(40, $urandom);
        finish_run(40, 1'b0);
        rdy_mode = 1'b0;
        tick();

        // Zero-length command: done two cycles after start, no beats.
        start_run(0, $urandom);
        @(negedge clk);
        check("zero_done_c1", done, 0);
        check("zero_busy_c1", busy, 0);
        @(negedge clk);
        check("zero_done_c2", done, 1);
        check("zero_busy_c2", busy, 0);
        @(negedge clk);
        check("zero_done_c3", done, 0);
        tick();
        repeat (3) tick();
        check("zero_beats", beat_cnt, 0);
        check("zero_done_cnt", done_cnt, 1);

        // Reset in the middle of a 20-word drain, then a short clean run.
        start_run(20, $urandom);
        wait_beats(7, 200);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs();
        end
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        repeat (2) tick();
        start_run(5, $urandom);
        finish_run(5, 1'b1);

        // A second start while busy must be ignored.
        start_run(8, $urandom);
        wait_beats(3, 200);
        num_words = (AW+1)'(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run(8, 1'b1);

        // Random lengths and random backpressure.
        for (int r = 0; r < 4; r++) begin
            rdy_mode = 1'($urandom_range(0, 1));
            start_run(int'($urandom_range(1, 48)), $urandom);
            finish_run(exp_q.size(), 1'b0);
            rdy_mode = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
